mfcc_frame_buffer: RTL
======================

# mfcc_frame_buffer

Parametrised ping-pong frame memory. The audio front end streams samples into one bank while the framing/FFT stage randomly reads the other. Each bank holds one analysis frame of FRAME_LEN words. Ownership of the two banks passes between writer and reader through full/release handshakes. It replaces the single-port, unmanaged sample RAM used between the front end and the FFT stage.

## Interface
- DATA_WIDTH, 32, sample/word width
- ADDR_WIDTH, 9, per-bank address width; 2^ADDR_WIDTH ≥ FRAME_LEN
- FRAME_LEN, 400, words per frame (25 ms at 16 kHz)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  sample present on wr_data
- wr_data  in  DATA_WIDTH  input sample
- wr_ready  out  1  writer owns a bank with free space
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  word index within the reader's frame
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data is valid this cycle
- frame_ready  out  1  reader owns a full bank
- rd_done  in  1  reader releases its bank (single-cycle pulse)
- overflow  out  1  sticky: a sample arrived while wr_ready=0

## Operation
- Storage: 2 × 2^ADDR_WIDTH × DATA_WIDTH, bank 0 and bank 1. Physical address = {bank, index}.
- Per-bank state: EMPTY, FULL. Writer pointer wsel and reader pointer rsel start at bank 0.
- Write accept: wr_valid & wr_ready. The word goes to [wsel][wptr] and wptr increments.
- On accepting word FRAME_LEN-1:
  - bank wsel becomes FULL and wptr returns to 0.
  - wsel toggles.
  - wr_ready stays 1 if the other bank is EMPTY after this cycle's updates. A bank released by rd_done in the same cycle counts as EMPTY.
  - Otherwise wr_ready goes to 0 until that bank is released.
- frame_ready = (bank rsel is FULL).
- Read accept: rd_en & frame_ready.
  - rd_data ← [rsel][rd_addr].
  - If rd_addr ≥ FRAME_LEN, rd_data ← 0 and rd_valid is still asserted.
  - rd_en while frame_ready=0 is ignored: rd_valid=0 and rd_data holds its value.
- rd_done while frame_ready=1: bank rsel becomes EMPTY and rsel toggles. rd_done while frame_ready=0 is ignored.
- Same-cycle rd_en and rd_done: the read completes from the old bank, then the release takes effect.
- Read and write always target different banks, so there is no read/write collision.
- overflow: set when wr_valid & !wr_ready. The sample is dropped and wptr is unchanged. Cleared only by rst.

## Timing
- Reset values:
  - wr_ready=1, frame_ready=0, rd_valid=0, rd_data=0, overflow=0.
  - wsel=rsel=0, wptr=0, both banks EMPTY.
  - Memory contents are not cleared.
- Reset mid-frame discards partial and full frames. wr_ready=1 on the first cycle after rst deasserts.
- Read latency is 1 cycle: request at edge N gives rd_data/rd_valid after edge N+1. rd_valid is a one-cycle pulse per accepted request. Back-to-back reads sustain 1 word/cycle.
- Write throughput is 1 word/cycle. wr_ready is registered and updates the cycle after the frame's last word or the releasing rd_done.
- frame_ready rises the cycle after the last word of a frame is accepted (when rsel points at that bank). It falls the cycle after rd_done.
- The writer may be one full frame ahead of the reader, and no more.

## Test plan
- FRAME_LEN=4, ADDR_WIDTH=2:
  - Stimulus: write 1,2,3,4; read addr 0..3.
  - Response: frame_ready=1 one cycle after the 4th write; rd_data=1,2,3,4, each one cycle after its request, with rd_valid high.
- Fill both banks (1..4, 5..8) with no rd_done:
  - wr_ready=0 after the 8th word.
  - A 9th wr_valid sets overflow=1, and that sample is not stored.
  - rd_done then gives wr_ready=1 next cycle, and frame_ready stays 1 (bank 1 full).
  - Reading addr 0 returns 5.
- Same-cycle release:
  - Stimulus: the writer accepts the last word of bank 1 in the cycle rd_done releases bank 0.
  - Response: wr_ready remains 1 with no bubble; the next sample lands in bank 0 addr 0.
- Boundary read:
  - rd_addr=3 with FRAME_LEN=3 → rd_data=0, rd_valid=1.
  - rd_en with frame_ready=0 → rd_valid=0 and rd_data unchanged.
- Reset mid-operation:
  - Stimulus: assert rst after 2 words of bank 1 with bank 0 full.
  - Response: next cycle frame_ready=0, wr_ready=1, overflow=0; the next 4 words form a frame in bank 0.

Source files
------------

// File: rtl/mfcc_frame_buffer_if.sv
// Writer/reader bus of the MFCC ping-pong frame buffer.
// The master side is the front end plus framing stage; the slave side is the buffer.
interface mfcc_frame_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  frame_ready;
    logic                  rd_done;
    logic                  overflow;

    modport master (
        output wr_valid, wr_data, rd_en, rd_addr, rd_done,
        input  wr_ready, rd_data, rd_valid, frame_ready, overflow
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, rd_addr, rd_done,
        output wr_ready, rd_data, rd_valid, frame_ready, overflow
    );
endinterface

// File: rtl/mfcc_frame_buffer.sv
// Ping-pong frame memory: the writer streams one bank while the reader randomly reads the
// other; full/release handshakes pass bank ownership back and forth.
module mfcc_frame_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int FRAME_LEN  = 400
) (
    input  logic                clk,
    input  logic                rst,
    mfcc_frame_buffer_if.slave  bus
);
    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH:0]   LEN      = (ADDR_WIDTH + 1)'(FRAME_LEN);

    logic [DATA_WIDTH-1:0] mem_q [2*DEPTH];

    logic [1:0]            full_q, full_d;
    logic                  wsel_q, wsel_d;
    logic                  rsel_q, rsel_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic                  wr_ready_q, wr_ready_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;

    logic frame_ready, wr_acc, wr_last, rd_acc, release_bank;

    always_comb begin
        frame_ready  = full_q[rsel_q];
        wr_acc       = bus.wr_valid & wr_ready_q;
        wr_last      = wr_acc && (wptr_q == LAST_IDX);
        rd_acc       = bus.rd_en & frame_ready;
        release_bank = bus.rd_done & frame_ready;

        full_d     = full_q;
        wsel_d     = wsel_q;
        rsel_d     = rsel_q;
        wptr_d     = wptr_q;
        rd_valid_d = rd_acc;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q | (bus.wr_valid & ~wr_ready_q);

        if (wr_acc)
            wptr_d = wr_last ? '0 : wptr_q + 1'b1;
        if (wr_last) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = ~wsel_q;
        end
        // Writer and reader never own the same bank, so set and clear cannot collide.
        if (release_bank) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end
        // Judged after this cycle's updates so a same-cycle release avoids a bubble.
        wr_ready_d = ~full_d[wsel_d];

        if (rd_acc)
            rd_data_d = ({1'b0, bus.rd_addr} >= LEN) ? '0 : mem_q[{rsel_q, bus.rd_addr}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            wptr_q     <= '0;
            wr_ready_q <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            wptr_q     <= wptr_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left uninitialised on reset; bank state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[{wsel_q, wptr_q}] <= bus.wr_data;
    end

    assign bus.wr_ready    = wr_ready_q;
    assign bus.frame_ready = frame_ready;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.overflow    = overflow_q;
endmodule
